// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit common-anode hex display driver with per-slot blanking and frame-synchronous shadow reload.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN suppresses leading-zero digits (digit 0 always shown).
module seg_scan_driver #(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] seg_data,
    output logic [7:0]  an,
    output logic [7:0]  ca,
    output logic        frame_tick
);

    localparam int CW = $clog2(SCAN_DIV);

    typedef enum logic {
        PH_BLANK,
        PH_DRIVE
    } phase_t;

    logic [CW-1:0] div_cnt_reg, div_cnt_next;
    logic [2:0]    digit_reg, digit_next;
    logic [31:0]   shadow_reg, shadow_next;
    logic          load_pending_reg;
    logic          div_wrap;
    logic          load;
    logic          in_blank;
    logic          digit_on;
    logic [3:0]    nibble;
    phase_t        slot_phase;
    logic [7:0]    an_next, ca_next;

    function automatic logic [7:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: return 8'hC0;
            4'h1: return 8'hF9;
            4'h2: return 8'hA4;
            4'h3: return 8'hB0;
            4'h4: return 8'h99;
            4'h5: return 8'h92;
            4'h6: return 8'h82;
            4'h7: return 8'hF8;
            4'h8: return 8'h80;
            4'h9: return 8'h90;
            4'hA: return 8'h88;
            4'hB: return 8'h83;
            4'hC: return 8'hC6;
            4'hD: return 8'hA1;
            4'hE: return 8'h86;
            default: return 8'h8E;
        endcase
    endfunction

    // Everything downstream is computed from the post-edge state so the
    // registered outputs always agree with div_cnt/digit/shadow.
    always_comb begin
        div_wrap     = (div_cnt_reg == CW'(SCAN_DIV - 1));
        div_cnt_next = div_wrap ? '0 : div_cnt_reg + CW'(1);
        digit_next   = div_wrap ? digit_reg + 3'd1 : digit_reg;
        load         = load_pending_reg || (div_wrap && (digit_reg == 3'd7));
        shadow_next  = load ? seg_data : shadow_reg;
        nibble       = shadow_next[4*digit_next +: 4];
    end

    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign in_blank = 1'b0;
        end else begin : g_blank
            assign in_blank = (32'(div_cnt_next) < 32'(BLANK_CYCLES));
        end
    endgenerate

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic [7:0] nib_nz;
    logic [2:0] lead_digit;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_nz
            assign nib_nz[gi] = |shadow_next[4*gi +: 4];
        end
    endgenerate

    always_comb begin
        lead_digit = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (nib_nz[i]) lead_digit = 3'(i);
        end
        digit_on = (digit_next <= lead_digit);
    end
`else
    assign digit_on = 1'b1;
`endif

    always_comb begin
        slot_phase = in_blank ? PH_BLANK : PH_DRIVE;
        an_next    = 8'hFF;
        ca_next    = 8'hFF;
        if (slot_phase == PH_DRIVE && digit_on) begin
            an_next = ~(8'd1 << digit_next);
            ca_next = hex7(nibble);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_reg      <= '0;
            digit_reg        <= 3'd0;
            shadow_reg       <= 32'd0;
            load_pending_reg <= 1'b1;
            an               <= 8'hFF;
            ca               <= 8'hFF;
            frame_tick       <= 1'b0;
        end else begin
            div_cnt_reg      <= div_cnt_next;
            digit_reg        <= digit_next;
            shadow_reg       <= shadow_next;
            load_pending_reg <= 1'b0;
            an               <= an_next;
            ca               <= ca_next;
            frame_tick       <= load;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (SCAN_DIV=8, BLANK_CYCLES=2) against a time-indexed reference model.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] seg_data = 32'd0;
    logic [7:0]  an, ca;
    logic        frame_tick;

    int n_tests = 0;
    int n_fail  = 0;
    int k       = 0;           // clock edges since reset release
    logic [31:0] shadow_m = 32'd0;
    logic [7:0]  hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    seg_scan_driver #(.SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_data   (seg_data),
        .an         (an),
        .ca         (ca),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s (edge %0d): got %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return $urandom >> $urandom_range(4, 31);
            2:       return 32'd0;
            default: return $urandom & 32'h0F0F_00FF;
        endcase
    endfunction

    // Model: after edge k the slot is k%8 within digit (k/8)%8; shadow reloads on edge 1 and every 64th edge.
    task automatic step(input bit rnd);
        int slot, d, m;
        bit et, lit;
        logic [7:0] ea, ec;
        @(posedge clk);
        #1;
        k++;
        et = (k == 1) || (k % 64 == 0);
        if (et) begin
            shadow_m = seg_data;
            $display("[TB] edge %0d: frame load %08h", k, shadow_m);
        end
        slot = k % 8;
        d    = (k / 8) % 8;
        m    = 0;
        for (int i = 0; i < 8; i++) if (shadow_m[4*i +: 4] != 4'd0) m = i;
        lit = 1'b1;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        lit = (d <= m);
`endif
        ea = 8'hFF;
        ec = 8'hFF;
        if (slot >= 2 && lit) begin
            ea = ~(8'd1 << d);
            ec = hex_tab[shadow_m[4*d +: 4]];
        end
        check("frame_tick", 32'(frame_tick), 32'(et));
        check("an", 32'(an), 32'(ea));
        check("ca", 32'(ca), 32'(ec));
        if (rnd && $urandom_range(0, 15) == 0) seg_data = rand_word();
    endtask

    initial begin
        int guard;
        // Held in reset: everything off.
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_an", 32'(an), 32'hFF);
            check("rst_ca", 32'(ca), 32'hFF);
            check("rst_tick", 32'(frame_tick), 32'd0);
        end

        seg_data = 32'h1234_5678;
        @(negedge clk);
        rst = 1'b1;
        k   = 0;
        repeat (64 + 27) step(1'b0);        // now inside digit 3 of the second frame
        seg_data = 32'hFFFF_FFFF;
        repeat (64 - 27 + 64) step(1'b0);
        seg_data = 32'h89AB_CDEF;
        repeat (128) step(1'b0);

        repeat (64 * 12) step(1'b1);

        // Asynchronous reset while digit 5 is lit.
        guard = 0;
        while (!(((k / 8) % 8 == 5) && (k % 8 >= 2)) && guard < 200) begin
            step(1'b1);
            guard++;
        end
        check("reach_digit5", 32'(guard < 200), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_an", 32'(an), 32'hFF);
        check("async_ca", 32'(ca), 32'hFF);
        check("async_tick", 32'(frame_tick), 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("hold_an", 32'(an), 32'hFF);
        end
        seg_data = rand_word();
        @(negedge clk);
        rst = 1'b1;
        k   = 0;
        repeat (64 * 4) step(1'b1);

        // Leading-zero patterns.
        seg_data = 32'h0000_0A05;
        while (k % 64 != 0) step(1'b0);
        repeat (64) step(1'b0);
        seg_data = 32'd0;
        repeat (128) step(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
